// File: rtl/router_pkg.sv
// router_pkg: shared header-field constants, entry layout and clog2 helper for the router FIFO
package router_pkg;
  localparam int LEN_LSB_DEF = 2;
  localparam int ADDR_MSB = LEN_LSB_DEF - 1;
  localparam int ADDR_LSB = 0;
  typedef struct packed {
    logic       hdr;
    logic [7:0] data;
  } entry_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/router_pkt_fifo_if.sv
// router_pkt_fifo_if: write/read handshake and status bundle of one router output FIFO
//   master: lfd_state, write_enb, data_in, read_enb out; data/status in
//   slave : the FIFO side of the same signals
interface router_pkt_fifo_if
  import router_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int AW = clog2(DEPTH);
  logic              lfd_state;
  logic              write_enb;
  logic [DATA_W-1:0] data_in;
  logic              read_enb;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              sop_out;
  logic              eop_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [AW:0]       fill_level;
  logic [AW:0]       pkt_count;
  logic              trunc_err;
  modport master (
    output lfd_state, write_enb, data_in, read_enb,
    input  data_out, out_valid, sop_out, eop_out, full, empty, almost_full,
           fill_level, pkt_count, trunc_err
  );
  modport slave (
    input  lfd_state, write_enb, data_in, read_enb,
    output data_out, out_valid, sop_out, eop_out, full, empty, almost_full,
           fill_level, pkt_count, trunc_err
  );
endinterface

// File: rtl/router_fifo_mem.sv
// router_fifo_mem: DEPTH x W register array, one write port, registered read port
//   clock; we/waddr/wdata write; re/raddr -> rdata next edge; peek_hdr = MSB of entry at raddr now
module router_fifo_mem #(
  parameter int W     = 9,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata,
  output logic          peek_hdr
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
  // header bit of the entry about to be popped, so the packet count moves on the pop edge
  assign peek_hdr = mem[raddr][W-1];
endmodule

// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware output FIFO with header flags, sop/eop marking, counts and truncation detect
//   clock, resetn (sync active-low), soft_reset (sync flush); bus: router_pkt_fifo_if slave
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int LEN_LSB   = LEN_LSB_DEF
) (
  input logic              clock,
  input logic              resetn,
  input logic              soft_reset,
  router_pkt_fifo_if.slave bus
);
  localparam int AW = clog2(DEPTH);
  localparam int LW = DATA_W - LEN_LSB;
  localparam int RW = LW + 1;
  logic [AW:0]     wr_ptr, rd_ptr, pkt_cnt;
  logic [RW-1:0]   rem;
  logic            lfd_d, clr_q, ov, terr;
  logic [DATA_W:0] rdata;
  logic            peek_hdr, flush, wr, rd, rhdr, bad;
  logic [LW-1:0]   len;
  assign flush = !resetn || soft_reset;
  assign wr    = bus.write_enb && !bus.full && !flush;
  assign rd    = bus.read_enb && !bus.empty && !flush;
  assign rhdr  = rdata[DATA_W];
  assign len   = rdata[DATA_W-1:LEN_LSB];
  // a header arriving mid-packet, or a payload word with no packet open
  assign bad   = rhdr ? (rem != '0) : (rem == '0);
  router_fifo_mem #(.W(DATA_W + 1), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clock   (clock),
    .we      (wr),
    .waddr   (wr_ptr[AW-1:0]),
    .wdata   ({lfd_d, bus.data_in}),
    .re      (rd),
    .raddr   (rd_ptr[AW-1:0]),
    .rdata   (rdata),
    .peek_hdr(peek_hdr)
  );
  assign bus.fill_level  = wr_ptr - rd_ptr;
  assign bus.empty       = wr_ptr == rd_ptr;
  assign bus.full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.almost_full = bus.fill_level >= AF_THRESH[AW:0];
  assign bus.pkt_count   = pkt_cnt;
  assign bus.trunc_err   = terr;
  assign bus.out_valid   = ov;
  assign bus.sop_out     = ov && rhdr;
  assign bus.eop_out     = ov && !rhdr && (rem == RW'(1));
  // the memory read register has no reset; clr_q masks it to zero until the first pop after a flush
  assign bus.data_out    = clr_q ? '0 : rdata[DATA_W-1:0];
  // packet tracking runs on the word currently presented (ov), one edge after its pop
  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= '0;
      rem     <= '0;
      lfd_d   <= 1'b0;
      clr_q   <= 1'b1;
      ov      <= 1'b0;
      terr    <= 1'b0;
    end else begin
      lfd_d   <= bus.lfd_state;
      ov      <= rd;
      wr_ptr  <= wr ? wr_ptr + (AW+1)'(1) : wr_ptr;
      rd_ptr  <= rd ? rd_ptr + (AW+1)'(1) : rd_ptr;
      clr_q   <= rd ? 1'b0 : clr_q;
      pkt_cnt <= pkt_cnt + (AW+1)'(wr && lfd_d) - (AW+1)'(rd && peek_hdr);
      rem     <= !ov ? rem : rhdr ? {1'b0, len} + RW'(1) : (rem == '0) ? '0 : rem - RW'(1);
      terr    <= terr || (ov && bad);
    end
  end
endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb_router_pkt_fifo: directed + randomized bench against a queue-based packet model
module tb_router_pkt_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  logic clk = 0;
  logic resetn, soft_reset;
  int errors = 0, checks = 0;
  bit armed = 0;
  router_pkt_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();
  router_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .LEN_LSB(2)) dut (
    .clock(clk), .resetn(resetn), .soft_reset(soft_reset), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  logic [DW:0] q[$];
  bit m_lfd, m_ov, m_vhdr, m_veop, m_pend, m_trunc, have_hdr;
  logic [DW-1:0] m_dout;
  int cur_len, pos;
  function automatic void chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endfunction
  function automatic int hdr_cnt();
    int c = 0;
    foreach (q[i]) c += int'(q[i][DW]);
    return c;
  endfunction
  function automatic void compare_all();
    chk("data_out", int'(bus.data_out), int'(m_dout));
    chk("out_valid", int'(bus.out_valid), int'(m_ov));
    chk("sop_out", int'(bus.sop_out), int'(m_ov && m_vhdr));
    chk("eop_out", int'(bus.eop_out), int'(m_ov && m_veop));
    chk("full", int'(bus.full), int'(q.size() == DEPTH));
    chk("empty", int'(bus.empty), int'(q.size() == 0));
    chk("almost_full", int'(bus.almost_full), int'(q.size() >= AF));
    chk("fill_level", int'(bus.fill_level), q.size());
    chk("pkt_count", int'(bus.pkt_count), hdr_cnt());
    chk("trunc_err", int'(bus.trunc_err), int'(m_trunc));
  endfunction
  // packet rules: word k after a header of length L ends the packet at k == L+1
  function automatic void model(input bit lfd, we, input logic [DW-1:0] d, input bit re, sr, rn);
    logic [DW:0] e;
    bit do_wr, do_rd;
    if (!rn || sr) begin
      q.delete();
      {m_lfd, m_ov, m_vhdr, m_veop, m_pend, m_trunc, have_hdr} = '0;
      m_dout = '0;
      cur_len = 0;
      pos = 0;
      return;
    end
    if (m_ov && m_pend) m_trunc = 1;
    do_rd = re && q.size() > 0;
    do_wr = we && q.size() < DEPTH;
    m_ov = do_rd;
    m_vhdr = 0;
    m_veop = 0;
    m_pend = 0;
    if (do_rd) begin
      e = q.pop_front();
      m_dout = e[DW-1:0];
      m_vhdr = e[DW];
      if (e[DW]) begin
        m_pend = have_hdr && pos < cur_len + 1;
        have_hdr = 1;
        cur_len = int'(e[DW-1:2]);
        pos = 0;
      end else begin
        pos++;
        m_veop = have_hdr && pos == cur_len + 1;
        m_pend = !have_hdr || pos > cur_len + 1;
      end
    end
    if (do_wr) q.push_back({m_lfd, d});
    m_lfd = lfd;
  endfunction
  task automatic cycle(input bit lfd, we, input logic [DW-1:0] d, input bit re, sr = 0, rn = 1);
    bus.lfd_state = lfd;
    bus.write_enb = we;
    bus.data_in = d;
    bus.read_enb = re;
    soft_reset = sr;
    resetn = rn;
    @(negedge clk);
    if (armed) compare_all();
    model(lfd, we, d, re, sr, rn);
    armed = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [DW-1:0] d, input bit h);
    if (h) cycle(1, 0, 0, 0);
    cycle(0, 1, d, 0);
  endtask
  task automatic pop();
    cycle(0, 0, 0, 1);
  endtask
  logic [DW-1:0] pkt [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h3E};
  initial begin
    bit pl;
    logic [DW-1:0] d;
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 8'hAA, 1, 0, 0);
    cycle(0, 0, 0, 1);
    chk("lit_empty_read_ov", int'(bus.out_valid), 0);
    chk("lit_empty_read_fill", int'(bus.fill_level), 0);
    for (int i = 0; i < 5; i++) send(pkt[i], i == 0);
    chk("lit_pkt_fill", int'(bus.fill_level), 5);
    chk("lit_pkt_count1", int'(bus.pkt_count), 1);
    pop();
    chk("lit_hdr_sop", int'(bus.sop_out), 1);
    chk("lit_hdr_data", int'(bus.data_out), 8'h0C);
    chk("lit_pkt_count0", int'(bus.pkt_count), 0);
    for (int i = 0; i < 4; i++) pop();
    chk("lit_par_eop", int'(bus.eop_out), 1);
    chk("lit_par_data", int'(bus.data_out), 8'h3E);
    chk("lit_drain_fill", int'(bus.fill_level), 0);
    for (int i = 0; i < 17; i++) begin
      cycle(0, 1, 8'(8'h40 + i), 0);
      if (i == 13) chk("lit_af_at14", int'(bus.almost_full), 1);
      if (i == 12) chk("lit_af_at13", int'(bus.almost_full), 0);
    end
    chk("lit_full", int'(bus.full), 1);
    cycle(0, 1, 8'hEE, 1);
    chk("lit_full_rw_fill", int'(bus.fill_level), 15);
    chk("lit_full_rw_data", int'(bus.data_out), 8'h40);
    for (int i = 0; i < 15; i++) pop();
    chk("lit_last_data", int'(bus.data_out), 8'h4F);
    chk("lit_fill_empty", int'(bus.empty), 1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) cycle(0, 1, 8'($urandom), i % 2 == 1);
      while (q.size() > 0) pop();
    end
    send(8'h10, 1);
    for (int i = 0; i < 5; i++) send(8'(8'h60 + i), 0);
    pop();
    pop();
    cycle(0, 0, 0, 0, 1);
    chk("lit_sr_fill", int'(bus.fill_level), 0);
    chk("lit_sr_empty", int'(bus.empty), 1);
    chk("lit_sr_ov", int'(bus.out_valid), 0);
    chk("lit_sr_pkt", int'(bus.pkt_count), 0);
    for (int i = 0; i < 5; i++) send(pkt[i], i == 0);
    for (int i = 0; i < 5; i++) pop();
    send(8'h10, 1);
    send(8'h71, 0);
    send(8'h72, 0);
    send(8'h04, 1);
    send(8'h73, 0);
    send(8'h74, 0);
    for (int i = 0; i < 6; i++) pop();
    chk("lit_trunc_set", int'(bus.trunc_err), 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    chk("lit_trunc_sticky", int'(bus.trunc_err), 1);
    cycle(0, 0, 0, 0, 1);
    chk("lit_trunc_clear", int'(bus.trunc_err), 0);
    pl = 0;
    for (int i = 0; i < 3000; i++) begin
      bit lfd, we, re;
      int bias = (i / 500) % 3;
      lfd = $urandom_range(0, 5) == 0;
      we = $urandom_range(0, 9) < (bias == 0 ? 7 : bias == 1 ? 3 : 5);
      re = $urandom_range(0, 9) < (bias == 0 ? 3 : bias == 1 ? 7 : 5);
      d = pl ? {4'h0, 4'($urandom)} : 8'($urandom);
      cycle(lfd, we, d, re, $urandom_range(0, 199) == 0, $urandom_range(0, 499) != 0);
      pl = lfd;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
